// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, prescale
// constants and the rule that maps an arbitrary prescale onto a legal one.
package uart_pkg;

    localparam int         DATA_BITS   = 8;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Anything other than 16 or 32 oversampling falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        if (p == PRESCALE_16 || p == PRESCALE_32) begin
            return p;
        end
        return PRESCALE_8;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the receiver: counts oversampling edges within a
// bit, captures three samples around mid-bit and votes on the bit value.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic [5:0] i_prescale,
    input  logic       i_rx,
    output logic       o_sampled_bit,
    output logic       o_bit_done,
    output logic       o_sample_ready
);

    logic [5:0] r_edge_cnt;
    logic [2:0] r_samples;
    logic [5:0] w_half;
    logic [2:0] w_sample_hit;

    assign w_half = {1'b0, i_prescale[5:1]};

    // Sample taps sit at mid-bit minus one, mid-bit and mid-bit plus one.
    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
        assign w_sample_hit[gi] = (r_edge_cnt == w_half + 6'(gi) - 6'd1);
    end

    assign o_bit_done     = (r_edge_cnt == i_prescale - 6'd1);
    assign o_sample_ready = (r_edge_cnt == w_half + 6'd2);
    assign o_sampled_bit  = (r_samples[0] & r_samples[1]) |
                            (r_samples[0] & r_samples[2]) |
                            (r_samples[1] & r_samples[2]);

    // Edge counter: runs while a frame is in progress, wraps every bit period.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run || o_bit_done) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
        end
    end

    // Capture the line at each of the three tap positions.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samples <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_sample_hit[i]) begin
                    r_samples[i] <= i_rx;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detection with glitch rejection, 8 data bits LSB
// first, optional parity, stop-bit check and one-cycle result pulses.
module uart_rx
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       parity_enable,
    input  logic       parity_type,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       busy
);

    rx_state_t  r_state;
    rx_state_t  w_state_next;
    logic [5:0] r_prescale;
    logic       r_par_en;
    logic       r_par_type;
    logic       r_armed;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par_bit;
    logic       r_stop_bit;
    logic [7:0] r_data;
    logic       r_dv;
    logic       r_pe;
    logic       r_se;

    logic       w_start_det;
    logic       w_run;
    logic       w_sampled_bit;
    logic       w_bit_done;
    logic       w_sample_ready;

    // r_armed stays low after reset until the line is seen high, so a reset
    // released in the middle of a low bit does not fake a start bit.
    assign w_start_det = (r_state == IDLE) && r_armed && !RX_IN;
    assign w_run       = (w_state_next != IDLE);

    uart_rx_sampler u_sampler (
        .i_clk          (CLK),
        .i_rst          (RST),
        .i_run          (w_run),
        .i_prescale     (r_prescale),
        .i_rx           (RX_IN),
        .o_sampled_bit  (w_sampled_bit),
        .o_bit_done     (w_bit_done),
        .o_sample_ready (w_sample_ready)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: frame sequencing driven by sampler timing strobes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_det) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_sample_ready && w_sampled_bit) begin
                    w_state_next = IDLE;
                end else if (w_bit_done) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_done && r_bit_cnt == 3'(DATA_BITS - 1)) begin
                    w_state_next = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch frame config, shift data, capture parity/stop, judge frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prescale <= PRESCALE_8;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b0;
            r_data     <= '0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            r_se <= 1'b0;
            if (RX_IN) begin
                r_armed <= 1'b1;
            end
            if (w_start_det) begin
                r_prescale <= legal_prescale(Prescale);
                r_par_en   <= parity_enable;
                r_par_type <= parity_type;
                r_bit_cnt  <= '0;
            end
            case (r_state)
                DATA: begin
                    if (w_sample_ready) begin
                        r_shift <= {w_sampled_bit, r_shift[7:1]};
                    end
                    if (w_bit_done) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (w_sample_ready) begin
                        r_par_bit <= w_sampled_bit;
                    end
                end
                STOP: begin
                    if (w_sample_ready) begin
                        r_stop_bit <= w_sampled_bit;
                    end
                    if (w_bit_done) begin
                        if (!r_stop_bit) begin
                            r_se <= 1'b1;
                        end else if (r_par_en && ((^r_shift) ^ r_par_bit ^ r_par_type)) begin
                            r_pe <= 1'b1;
                        end else begin
                            r_dv   <= 1'b1;
                            r_data <= r_shift;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign P_DATA       = r_data;
    assign Data_Valid   = r_dv;
    assign parity_error = r_pe;
    assign stop_error   = r_se;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed and random frames against a frame-level
// model that predicts which result pulse appears, when, and with what data.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_type;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_err;
    logic       stop_err;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [2:0] kind;   // {stop_error, parity_error, Data_Valid}
        logic [7:0] data;
    } ev_t;

    ev_t  act_q[$];
    ev_t  exp_q[$];
    ev_t  last_act[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    logic [7:0] last_good = 8'h00;

    uart_rx dut (
        .CLK           (clk),
        .RST           (rst),
        .RX_IN         (rx_in),
        .Prescale      (prescale),
        .parity_enable (par_en),
        .parity_type   (par_type),
        .P_DATA        (p_data),
        .Data_Valid    (data_valid),
        .parity_error  (parity_err),
        .stop_error    (stop_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse with the cycle it is visible in.
    always @(negedge clk) begin
        if (mon_en && (data_valid || parity_err || stop_err)) begin
            ev_t e;
            e.cyc  = cyc + 1;
            e.kind = {stop_err, parity_err, data_valid};
            e.data = p_data;
            act_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input logic [5:0] p);
        return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    // Frame-level reference: outcome and timing from the frame's contents.
    task automatic model_frame(input logic [7:0] d, input logic [5:0] praw, input logic pe,
                               input logic bad_par, input logic stop_val, input int t0);
        ev_t e;
        e.cyc = t0 + (pe ? 11 : 10) * eff_p(praw);
        if (!stop_val) begin
            e.kind = 3'b100;
            e.data = last_good;
        end else if (pe && bad_par) begin
            e.kind = 3'b010;
            e.data = last_good;
        end else begin
            e.kind = 3'b001;
            e.data = d;
            last_good = d;
        end
        exp_q.push_back(e);
    endtask

    // Drive one frame starting at the current negedge; max_cycles>0 aborts early.
    task automatic send_frame(input logic [7:0] d, input logic [5:0] praw, input logic pe,
                              input logic pt, input logic bad_par, input logic stop_val,
                              input int max_cycles, output int t0);
        logic [10:0] bits;
        int p, nb, driven;
        p = eff_p(praw);
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) begin
            bits[9]  = (^d) ^ pt ^ bad_par;
            bits[10] = stop_val;
            nb = 11;
        end else begin
            bits[9] = stop_val;
            nb = 10;
        end
        prescale = praw;
        par_en   = pe;
        par_type = pt;
        t0 = cyc + 1;
        driven = 0;
        for (int b = 0; b < nb; b++) begin
            rx_in = bits[b];
            for (int k = 0; k < p; k++) begin
                if (max_cycles > 0 && driven == max_cycles) return;
                @(negedge clk);
                driven++;
                if (b == 0 && k == 0) begin
                    // Config changes mid-frame must not disturb this frame.
                    prescale = 6'($urandom_range(0, 63));
                    par_en   = 1'($urandom);
                    par_type = 1'($urandom);
                end
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic expect_events(input string tag);
        int n;
        for (int i = 0; i < 800 && act_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, 32'(act_q[i].cyc), 32'(exp_q[i].cyc));
            check({tag, "_kind"},  32'(act_q[i].kind), 32'(exp_q[i].kind));
            check({tag, "_data"},  32'(act_q[i].data), 32'(exp_q[i].data));
        end
        check({tag, "_pdata_now"}, 32'(p_data), 32'(last_good));
        last_act = act_q;
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t0, t1;
        logic [7:0] d;
        logic [5:0] pr;
        logic pe, pt, bp, sv;

        rst = 1'b1;
        rx_in = 1'b1;
        prescale = 6'd8;
        par_en = 1'b0;
        par_type = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pdata", 32'(p_data), 32'h00);
        check("rst_dv",    32'(data_valid), 32'h0);
        check("rst_pe",    32'(parity_err), 32'h0);
        check("rst_se",    32'(stop_err), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // P=8, even parity, 0xA5, good frame
        send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 0, t0);
        model_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, t0);
        expect_events("p8_even_a5");
        check("p8_even_a5_latency", 32'((last_act.size() > 0) ? last_act[0].cyc - t0 : -1), 32'd88);
        repeat (2) @(negedge clk);

        // P=16, no parity, 0x3C
        send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 0, t0);
        model_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b1, t0);
        expect_events("p16_3c");
        check("p16_3c_latency", 32'((last_act.size() > 0) ? last_act[0].cyc - t0 : -1), 32'd160);
        repeat (2) @(negedge clk);

        // P=8, odd parity, 0x01 with parity bit 1 -> parity error
        send_frame(8'h01, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1, 0, t0);
        model_frame(8'h01, 6'd8, 1'b1, 1'b1, 1'b1, t0);
        expect_events("p8_odd_bad");
        repeat (2) @(negedge clk);

        // P=32, stop bit 0 -> stop error
        send_frame(8'h96, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 0, t0);
        model_frame(8'h96, 6'd32, 1'b0, 1'b0, 1'b0, t0);
        expect_events("p32_stop0");
        repeat (2) @(negedge clk);

        // P=32, 3-cycle low glitch -> busy, then quiet return to IDLE
        prescale = 6'd32;
        par_en = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        check("glitch_busy_high", 32'(busy), 32'h1);
        repeat (40) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 32'h0);
        expect_events("glitch");

        // Back-to-back 0xFF then 0x00 at P=8, no parity
        send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, t0);
        send_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, t1);
        model_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b1, t0);
        model_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b1, t1);
        expect_events("b2b");
        check("b2b_spacing", 32'((last_act.size() >= 2) ? last_act[1].cyc - last_act[0].cyc : -1), 32'd80);
        repeat (2) @(negedge clk);

        // Reset during data bit 4 of a P=8 frame
        send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 5 * 8 + 3, t0);
        rst = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("midrst_busy",  32'(busy), 32'h0);
        check("midrst_pdata", 32'(p_data), 32'h00);
        check("midrst_dv",    32'(data_valid), 32'h0);
        check("midrst_pe",    32'(parity_err), 32'h0);
        check("midrst_se",    32'(stop_err), 32'h0);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (4) @(negedge clk);
        send_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, t0);
        model_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b1, t0);
        expect_events("post_rst");
        repeat (2) @(negedge clk);

        // Random frames, including illegal prescale values
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            case ($urandom_range(0, 3))
                0: pr = 6'd8;
                1: pr = 6'd16;
                2: pr = 6'd32;
                default: pr = 6'($urandom_range(0, 63));
            endcase
            pe = 1'($urandom);
            pt = 1'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 4) != 0);
            send_frame(d, pr, pe, pt, bp, sv, 0, t0);
            model_frame(d, pr, pe, bp, sv, t0);
            expect_events("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
